// File: rtl/aes_src_dma_if.sv
// Bus bundle for the AES source DMA: control slave, memory read master
// and cipher-side write master.
interface aes_src_dma_if;
    logic        ctl_chipselect;
    logic [1:0]  ctl_address;
    logic        ctl_write;
    logic [31:0] ctl_writedata;
    logic        ctl_read;
    logic [31:0] ctl_readdata;

    logic [31:0] m_address;
    logic        m_read;
    logic [31:0] m_readdata;
    logic        m_waitrequest;

    logic        aes_chipselect;
    logic [3:0]  aes_address;
    logic        aes_write;
    logic [31:0] aes_writedata;
    logic        aes_waitrequest;

    // The DMA engine side.
    modport master (
        input  ctl_chipselect, ctl_address, ctl_write, ctl_writedata, ctl_read,
        output ctl_readdata,
        output m_address, m_read,
        input  m_readdata, m_waitrequest,
        output aes_chipselect, aes_address, aes_write, aes_writedata,
        input  aes_waitrequest
    );

    // The system side: CPU, memory and cipher core.
    modport slave (
        output ctl_chipselect, ctl_address, ctl_write, ctl_writedata, ctl_read,
        input  ctl_readdata,
        input  m_address, m_read,
        output m_readdata, m_waitrequest,
        input  aes_chipselect, aes_address, aes_write, aes_writedata,
        output aes_waitrequest
    );
endinterface

// File: rtl/aes_src_dma.sv
// Streams NBLOCKS 128-bit blocks from memory into the cipher plaintext port,
// one word read followed by one word write; abort only takes effect on a block boundary.
//
// state | meaning
// IDLE  | waiting for a start write to CTRL
// RD    | memory read of the word at the working address
// WR    | presenting the buffered word to the cipher plaintext port
// FIN   | one cycle: flag done, drop any pending abort
module aes_src_dma (
    input  logic          clock,
    input  logic          resetn,
    aes_src_dma_if.master bus
);
    typedef enum logic [1:0] {IDLE, RD, WR, FIN} state_t;

    state_t      state;
    logic [31:0] src_addr;
    logic [15:0] nblocks;
    logic [15:0] remaining;
    logic [1:0]  word_cnt;
    logic [31:0] work_addr;
    logic [31:0] word_buf;
    logic        abort_pend;
    logic        done;
    logic        m_read_q;
    logic        aes_wr_q;

    logic ctl_wr;
    logic busy;

    assign ctl_wr = bus.ctl_chipselect & bus.ctl_write;
    assign busy   = (state != IDLE);

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state      <= IDLE;
            src_addr   <= '0;
            nblocks    <= '0;
            remaining  <= '0;
            word_cnt   <= '0;
            work_addr  <= '0;
            word_buf   <= '0;
            abort_pend <= 1'b0;
            done       <= 1'b0;
            m_read_q   <= 1'b0;
            aes_wr_q   <= 1'b0;
        end else begin
            if (ctl_wr && bus.ctl_address == 2'd2 && bus.ctl_writedata[1] && busy)
                abort_pend <= 1'b1;

            case (state)
                IDLE: begin
                    if (ctl_wr && bus.ctl_address == 2'd0)
                        src_addr <= {bus.ctl_writedata[31:2], 2'b00};
                    if (ctl_wr && bus.ctl_address == 2'd1)
                        nblocks <= bus.ctl_writedata[15:0];
                    if (ctl_wr && bus.ctl_address == 2'd2 && bus.ctl_writedata[0]) begin
                        work_addr <= src_addr;
                        remaining <= nblocks;
                        word_cnt  <= 2'd0;
                        done      <= 1'b0;
                        if (nblocks == 16'd0) begin
                            state <= FIN;
                        end else begin
                            state    <= RD;
                            m_read_q <= 1'b1;
                        end
                    end
                end
                RD: begin
                    if (!bus.m_waitrequest) begin
                        word_buf <= bus.m_readdata;
                        m_read_q <= 1'b0;
                        aes_wr_q <= 1'b1;
                        state    <= WR;
                    end
                end
                WR: begin
                    if (!bus.aes_waitrequest) begin
                        aes_wr_q  <= 1'b0;
                        work_addr <= work_addr + 32'd4;
                        word_cnt  <= word_cnt + 2'd1;
                        // Only a completed block may end the transfer.
                        if (word_cnt == 2'd3 && (remaining == 16'd1 || abort_pend)) begin
                            remaining <= remaining - 16'd1;
                            state     <= FIN;
                        end else begin
                            if (word_cnt == 2'd3)
                                remaining <= remaining - 16'd1;
                            m_read_q <= 1'b1;
                            state    <= RD;
                        end
                    end
                end
                FIN: begin
                    done       <= 1'b1;
                    abort_pend <= 1'b0;
                    state      <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

    assign bus.m_address      = work_addr;
    assign bus.m_read         = m_read_q;
    assign bus.aes_chipselect = aes_wr_q;
    assign bus.aes_write      = aes_wr_q;
    assign bus.aes_address    = 4'h0;
    assign bus.aes_writedata  = word_buf;

    always_comb begin
        bus.ctl_readdata = 32'd0;
        if (bus.ctl_chipselect && bus.ctl_read) begin
            case (bus.ctl_address)
                2'd0:    bus.ctl_readdata = src_addr;
                2'd1:    bus.ctl_readdata = {16'd0, nblocks};
                2'd3:    bus.ctl_readdata = {remaining, 14'd0, done, busy};
                default: bus.ctl_readdata = 32'd0;
            endcase
        end
    end
endmodule

// File: tb/tb_aes_src_dma.sv
// Scoreboard bench for aes_src_dma: directed transfers push expected read
// addresses and cipher words; a negedge monitor pops and compares them.
module tb_aes_src_dma;
    logic clock = 1'b0;
    logic resetn = 1'b0;
    always #5 clock = ~clock;

    aes_src_dma_if bus();

    aes_src_dma dut (
        .clock  (clock),
        .resetn (resetn),
        .bus    (bus)
    );

    // Memory returns its own address tagged in the upper half.
    assign bus.m_readdata = bus.m_address ^ 32'h5A5A_0000;

    int n_pass = 0;
    int n_total = 0;
    int rd_count = 0;
    int wr_count = 0;
    logic [31:0] exp_addr[$];
    logic [31:0] exp_data[$];

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h expected 0x%08h", name, got, exp);
    endtask

    always @(negedge clock) begin
        if (bus.m_read && !bus.m_waitrequest) begin
            rd_count++;
            if (exp_addr.size() == 0) begin
                n_total++;
                $display("FAIL rd_unexpected: got read at 0x%08h expected no read", bus.m_address);
            end else begin
                check("rd_addr", bus.m_address, exp_addr.pop_front());
            end
        end
        if (bus.aes_write && !bus.aes_waitrequest) begin
            wr_count++;
            check("aes_cs_addr", {27'd0, bus.aes_chipselect, bus.aes_address}, 32'h0000_0010);
            if (exp_data.size() == 0) begin
                n_total++;
                $display("FAIL wr_unexpected: got write 0x%08h expected no write", bus.aes_writedata);
            end else begin
                check("aes_data", bus.aes_writedata, exp_data.pop_front());
            end
        end
    end

    task automatic reg_wr(input logic [1:0] a, input logic [31:0] d);
        @(posedge clock); #1;
        bus.ctl_chipselect = 1'b1;
        bus.ctl_write      = 1'b1;
        bus.ctl_address    = a;
        bus.ctl_writedata  = d;
        @(posedge clock); #1;
        bus.ctl_chipselect = 1'b0;
        bus.ctl_write      = 1'b0;
    endtask

    task automatic reg_rd(input logic [1:0] a, output logic [31:0] d);
        bus.ctl_chipselect = 1'b1;
        bus.ctl_read       = 1'b1;
        bus.ctl_address    = a;
        #1;
        d = bus.ctl_readdata;
        bus.ctl_read       = 1'b0;
        bus.ctl_chipselect = 1'b0;
    endtask

    task automatic wait_done(input int budget);
        logic [31:0] s;
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #1;
            reg_rd(2'd3, s);
            if (s[1] && !s[0]) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL done_timeout: got still busy expected done within %0d cycles", budget);
        end
    endtask

    task automatic wait_wr(input int target, input int budget);
        bit ok;
        ok = 1'b0;
        for (int i = 0; i < budget; i++) begin
            @(posedge clock); #1;
            if (wr_count >= target) begin
                ok = 1'b1;
                break;
            end
        end
        if (!ok) begin
            n_total++;
            $display("FAIL wr_timeout: got %0d writes expected %0d", wr_count, target);
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got no finish expected finish by 200000");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] s;
        int rd0, wr0;

        bus.ctl_chipselect  = 1'b0;
        bus.ctl_address     = 2'd0;
        bus.ctl_write       = 1'b0;
        bus.ctl_writedata   = 32'd0;
        bus.ctl_read        = 1'b0;
        bus.m_waitrequest   = 1'b0;
        bus.aes_waitrequest = 1'b0;

        // Reset state
        repeat (3) @(posedge clock);
        #1;
        check("rst_m_read", {31'd0, bus.m_read}, 32'd0);
        check("rst_aes_write", {31'd0, bus.aes_write}, 32'd0);
        reg_rd(2'd3, s); check("rst_status", s, 32'd0);
        reg_rd(2'd0, s); check("rst_src", s, 32'd0);
        resetn = 1'b1;

        // One block, zero wait; low address bits are dropped
        reg_wr(2'd0, 32'h0000_1003);
        reg_rd(2'd0, s); check("src_align", s, 32'h0000_1000);
        reg_wr(2'd1, 32'd1);
        reg_rd(2'd1, s); check("nblocks_rd", s, 32'd1);
        exp_addr.push_back(32'h0000_1000); exp_data.push_back(32'h5A5A_1000);
        exp_addr.push_back(32'h0000_1004); exp_data.push_back(32'h5A5A_1004);
        exp_addr.push_back(32'h0000_1008); exp_data.push_back(32'h5A5A_1008);
        exp_addr.push_back(32'h0000_100C); exp_data.push_back(32'h5A5A_100C);
        rd0 = rd_count; wr0 = wr_count;
        reg_wr(2'd2, 32'd1);
        repeat (8) @(posedge clock);
        #1;
        reg_rd(2'd3, s); check("a_status_fin", s, 32'h0000_0001);
        @(posedge clock); #1;
        reg_rd(2'd3, s); check("a_status_9cyc", s, 32'h0000_0002);
        check("a_reads", rd_count - rd0, 4);
        check("a_writes", wr_count - wr0, 4);

        // Zero blocks
        reg_wr(2'd1, 32'd0);
        rd0 = rd_count; wr0 = wr_count;
        reg_wr(2'd2, 32'd1);
        reg_rd(2'd3, s); check("b_status_1cyc", s, 32'h0000_0001);
        @(posedge clock); #1;
        reg_rd(2'd3, s); check("b_status_2cyc", s, 32'h0000_0002);
        check("b_reads", rd_count - rd0, 0);
        check("b_writes", wr_count - wr0, 0);

        // Abort in IDLE is dropped; start+abort acts as start; stall on word 3
        reg_wr(2'd2, 32'd2);
        reg_wr(2'd0, 32'h0000_2000);
        reg_wr(2'd1, 32'd2);
        for (int i = 0; i < 8; i++) begin
            exp_addr.push_back(32'h0000_2000 + 32'(4 * i));
            exp_data.push_back(32'h5A5A_2000 + 32'(4 * i));
        end
        rd0 = rd_count; wr0 = wr_count;
        reg_wr(2'd2, 32'd3);
        wait_wr(wr0 + 3, 50);
        bus.aes_waitrequest = 1'b1;
        @(posedge clock);
        for (int i = 0; i < 5; i++) begin
            @(negedge clock);
            check("c_stall_data", bus.aes_writedata, 32'h5A5A_200C);
            check("c_stall_write", {31'd0, bus.aes_write}, 32'd1);
            check("c_stall_no_read", {31'd0, bus.m_read}, 32'd0);
            @(posedge clock);
        end
        #1;
        bus.aes_waitrequest = 1'b0;
        wait_done(100);
        check("c_writes", wr_count - wr0, 8);
        check("c_reads", rd_count - rd0, 8);
        reg_rd(2'd3, s); check("c_status", s, 32'h0000_0002);

        // Abort during word 1 of block 0; config writes while busy ignored
        reg_wr(2'd0, 32'h0000_3000);
        reg_wr(2'd1, 32'd3);
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'h0000_3000 + 32'(4 * i));
            exp_data.push_back(32'h5A5A_3000 + 32'(4 * i));
        end
        rd0 = rd_count; wr0 = wr_count;
        reg_wr(2'd2, 32'd1);
        wait_wr(wr0 + 1, 50);
        reg_wr(2'd2, 32'd2);
        reg_wr(2'd0, 32'h0000_9000);
        reg_wr(2'd1, 32'd5);
        wait_done(100);
        check("d_writes", wr_count - wr0, 4);
        check("d_reads", rd_count - rd0, 4);
        reg_rd(2'd3, s); check("d_status", s, 32'h0002_0002);
        reg_rd(2'd0, s); check("d_src_kept", s, 32'h0000_3000);
        reg_rd(2'd1, s); check("d_nblocks_kept", s, 32'd3);

        // Address wrap at 2^32, with a memory stall on the first read
        reg_wr(2'd0, 32'hFFFF_FFF8);
        reg_wr(2'd1, 32'd1);
        exp_addr.push_back(32'hFFFF_FFF8); exp_data.push_back(32'hA5A5_FFF8);
        exp_addr.push_back(32'hFFFF_FFFC); exp_data.push_back(32'hA5A5_FFFC);
        exp_addr.push_back(32'h0000_0000); exp_data.push_back(32'h5A5A_0000);
        exp_addr.push_back(32'h0000_0004); exp_data.push_back(32'h5A5A_0004);
        rd0 = rd_count; wr0 = wr_count;
        bus.m_waitrequest = 1'b1;
        reg_wr(2'd2, 32'd1);
        repeat (3) @(posedge clock);
        #1;
        bus.m_waitrequest = 1'b0;
        wait_done(100);
        check("e_writes", wr_count - wr0, 4);
        check("e_reads", rd_count - rd0, 4);

        // Reset during WR of word 2; word 2 is on the bus in that cycle
        reg_wr(2'd0, 32'h0000_4000);
        reg_wr(2'd1, 32'd1);
        for (int i = 0; i < 3; i++) begin
            exp_addr.push_back(32'h0000_4000 + 32'(4 * i));
            exp_data.push_back(32'h5A5A_4000 + 32'(4 * i));
        end
        rd0 = rd_count; wr0 = wr_count;
        reg_wr(2'd2, 32'd1);
        wait_wr(wr0 + 2, 50);
        @(posedge clock); #1;
        resetn = 1'b0;
        @(posedge clock); #1;
        check("f_m_read", {31'd0, bus.m_read}, 32'd0);
        check("f_aes_write", {30'd0, bus.aes_chipselect, bus.aes_write}, 32'd0);
        check("f_m_address", bus.m_address, 32'd0);
        reg_rd(2'd3, s); check("f_status", s, 32'd0);
        @(posedge clock); #1;
        resetn = 1'b1;
        repeat (3) @(posedge clock);
        #1;
        check("f_reads", rd_count - rd0, 3);
        check("f_writes", wr_count - wr0, 3);

        reg_wr(2'd0, 32'h0000_5000);
        reg_wr(2'd1, 32'd1);
        for (int i = 0; i < 4; i++) begin
            exp_addr.push_back(32'h0000_5000 + 32'(4 * i));
            exp_data.push_back(32'h5A5A_5000 + 32'(4 * i));
        end
        rd0 = rd_count; wr0 = wr_count;
        reg_wr(2'd2, 32'd1);
        wait_done(100);
        check("g_writes", wr_count - wr0, 4);
        reg_rd(2'd3, s); check("g_status", s, 32'h0000_0002);

        repeat (3) @(posedge clock);
        check("q_addr_empty", exp_addr.size(), 0);
        check("q_data_empty", exp_data.size(), 0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
